// File: rtl/ps2_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_pkg: shared PS/2 link types, frame constants and keyboard command codes
// Revision: 1.0
// ----------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SHIFT     = 3'd3,
        WAIT_IDLE = 3'd4
    } ps2_state_e;

    // Device clock falls per host-to-device frame: 8 data + parity + stop + ACK
    localparam int FRAME_EDGES = 11;

    localparam logic [7:0] CMD_SET_LED = 8'hED;
    localparam logic [7:0] CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] CMD_RESET   = 8'hFF;
    localparam logic [7:0] RESP_ACK    = 8'hFA;

endpackage
`default_nettype wire

// File: rtl/ps2_line_sync.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_line_sync: 2-flop synchronisers for the PS/2 lines plus clock-fall detect
// Revision: 1.0
// ----------------------------------------------------------------------------
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_in,
    input  logic ps2_data_in,
    output logic clk_sync,
    output logic data_sync,
    output logic clk_fall
);

    // Third clock stage holds the previous synchronised value for edge detect
    logic [2:0] clk_pipe_q;
    logic [2:0] clk_pipe_d;
    logic [1:0] data_pipe_q;
    logic [1:0] data_pipe_d;

    always_comb begin
        clk_pipe_d  = {clk_pipe_q[1:0], ps2_clk_in};
        data_pipe_d = {data_pipe_q[0], ps2_data_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_pipe_q  <= 3'b111;
            data_pipe_q <= 2'b11;
        end else begin
            clk_pipe_q  <= clk_pipe_d;
            data_pipe_q <= data_pipe_d;
        end
    end

    assign clk_sync  = clk_pipe_q[1];
    assign data_sync = data_pipe_q[1];
    assign clk_fall  = clk_pipe_q[2] & ~clk_pipe_q[1];

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_host_tx: PS/2 host-to-device command transmitter with ACK/timeout report
// Revision: 1.0
// ----------------------------------------------------------------------------
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int              INH_W      = $clog2(INHIBIT_CYCLES) + 1;
    localparam int              TO_W       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [INH_W-1:0] INH_LAST  = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       EDGES_ALL = 4'(FRAME_EDGES);
    localparam logic [3:0]       EDGES_TX  = 4'(FRAME_EDGES - 1);

    logic w_clk_sync;
    logic w_data_sync;
    logic w_clk_fall;

    ps2_line_sync u_line_sync (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .clk_sync    (w_clk_sync),
        .data_sync   (w_data_sync),
        .clk_fall    (w_clk_fall)
    );

    ps2_state_e        state_q, state_d;
    logic [9:0]        frame_q, frame_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [INH_W-1:0]  inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              ack_ok_q, ack_ok_d;
    logic              clk_oe_q, clk_oe_d;
    logic              data_oe_q, data_oe_d;
    logic              done_q, done_d;
    logic              ack_err_q, ack_err_d;
    logic              timeout_err_q, timeout_err_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;

    logic w_accept;
    logic w_timed;
    logic w_timeout;
    logic w_last_edge;
    logic w_complete;

    assign w_accept    = (state_q == IDLE) && tx_valid && ready_q;
    assign w_timed     = (state_q == START) || (state_q == SHIFT) || (state_q == WAIT_IDLE);
    assign w_timeout   = w_timed && (to_cnt_q == TO_LAST);
    assign w_last_edge = (state_q == SHIFT) && w_clk_fall && (bit_cnt_q == EDGES_TX);
    assign w_complete  = (state_q == WAIT_IDLE) && w_clk_sync && w_data_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            bit_cnt_q     <= '0;
            inh_cnt_q     <= '0;
            to_cnt_q      <= '0;
            ack_ok_q      <= 1'b0;
            clk_oe_q      <= 1'b0;
            data_oe_q     <= 1'b0;
            done_q        <= 1'b0;
            ack_err_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            ready_q       <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_q       <= frame_d;
            bit_cnt_q     <= bit_cnt_d;
            inh_cnt_q     <= inh_cnt_d;
            to_cnt_q      <= to_cnt_d;
            ack_ok_q      <= ack_ok_d;
            clk_oe_q      <= clk_oe_d;
            data_oe_q     <= data_oe_d;
            done_q        <= done_d;
            ack_err_q     <= ack_err_d;
            timeout_err_q <= timeout_err_d;
            ready_q       <= ready_d;
            busy_q        <= busy_d;
        end
    end

    // Completion is tested before timeout in WAIT_IDLE so it wins a tie
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (w_accept) state_d = INHIBIT;
            INHIBIT:   if (inh_cnt_q == INH_LAST) state_d = START;
            START:     state_d = w_timeout ? IDLE : SHIFT;
            SHIFT: begin
                if (w_timeout)        state_d = IDLE;
                else if (w_last_edge) state_d = WAIT_IDLE;
            end
            WAIT_IDLE: if (w_complete || w_timeout) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        frame_d   = frame_q;
        bit_cnt_d = bit_cnt_q;
        inh_cnt_d = inh_cnt_q;
        to_cnt_d  = to_cnt_q;
        ack_ok_d  = ack_ok_q;
        if (w_accept) begin
            frame_d   = {1'b1, ~^tx_data, tx_data};
            bit_cnt_d = '0;
            inh_cnt_d = '0;
            to_cnt_d  = '0;
        end
        if (state_q == INHIBIT) inh_cnt_d = inh_cnt_q + 1'b1;
        if (w_timed)            to_cnt_d  = to_cnt_q + 1'b1;
        if ((state_q == SHIFT) && w_clk_fall && (bit_cnt_q != EDGES_ALL))
            bit_cnt_d = bit_cnt_q + 1'b1;
        if (w_last_edge) ack_ok_d = ~w_data_sync;
    end

    // Outputs are registered from the next state so the open-drain enables never glitch
    always_comb begin
        clk_oe_d  = (state_d == INHIBIT) || (state_d == START);
        data_oe_d = 1'b0;
        case (state_d)
            START: data_oe_d = 1'b1;
            SHIFT: begin
                data_oe_d = data_oe_q;
                if ((state_q == SHIFT) && w_clk_fall && (bit_cnt_q < EDGES_TX))
                    data_oe_d = ~frame_q[bit_cnt_q];
            end
            default: data_oe_d = 1'b0;
        endcase
        done_d        = w_timed && (state_d == IDLE);
        ack_err_d     = w_complete && ~ack_ok_q;
        timeout_err_d = done_d && ~w_complete;
        ready_d       = (state_d == IDLE);
        busy_d        = (state_d != IDLE);
    end

    assign tx_ready    = ready_q;
    assign tx_busy     = busy_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout_err = timeout_err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ps2_host_tx: directed bench with a PS/2 device model and reference model
// Revision: 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH  = 20;
    localparam int TMO  = 2000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_busy, done, ack_err, timeout_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_drv = 1'b1;
    logic       dev_data_drv = 1'b1;
    logic       ps2_clk_line, ps2_data_line;

    assign ps2_clk_line  = ~ps2_clk_oe & dev_clk_drv;
    assign ps2_data_line = ~ps2_data_oe & dev_data_drv;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_busy     (tx_busy),
        .done        (done),
        .ack_err     (ack_err),
        .timeout_err (timeout_err),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    int   done_cnt = 0;
    int   cyc = 0;
    int   inh_run = 0;
    int   start_run = 0;
    int   start_cyc = 0;
    logic exp_ack_err = 1'b0;
    logic exp_to_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic bound_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=expired required=event_within_bound", name);
    endtask

    // Reference frame as the device sees it: start, data LSB first, odd parity, stop
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, b, 1'b0};
    endfunction

    // Per-cycle compare against the protocol rules and the expected outcome flags
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                inh_run   = 0;
                start_run = 0;
            end else begin
                check("ready_vs_busy", 32'(tx_ready), 32'(!tx_busy));
                if (done) begin
                    done_cnt++;
                    check("done_ack_err", 32'(ack_err), 32'(exp_ack_err));
                    check("done_timeout_err", 32'(timeout_err), 32'(exp_to_err));
                    if (exp_to_err) check("timeout_latency", 32'(cyc - start_cyc), 32'(TMO));
                end else begin
                    check("flags_quiet", {30'd0, ack_err, timeout_err}, 32'd0);
                end
                if (ps2_clk_oe && !ps2_data_oe) begin
                    inh_run++;
                end else if (ps2_clk_oe && ps2_data_oe) begin
                    if (start_run == 0) begin
                        check("inhibit_len", 32'(inh_run), 32'(INH));
                        start_cyc = cyc;
                    end
                    start_run++;
                    inh_run = 0;
                end else begin
                    if (start_run != 0) check("start_len", 32'(start_run), 32'd1);
                    start_run = 0;
                    inh_run   = 0;
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int w = 0;
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        while (!tx_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!tx_ready) bound_fail("accept_wait");
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device: waits for request-to-send, then clocks n_falls edges, sampling on rises
    task automatic dev_run(input int n_falls, input logic do_ack, output logic [10:0] s);
        int w = 0;
        s = '0;
        while (!(!ps2_clk_oe && ps2_data_oe) && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!(!ps2_clk_oe && ps2_data_oe)) begin
            bound_fail("rts_wait");
            return;
        end
        s[0] = ps2_data_line;
        repeat (HALF) @(negedge clk);
        for (int n = 1; n <= n_falls; n++) begin
            if (n == FRAME_EDGES) begin
                dev_data_drv = ~do_ack;
                repeat (10) @(negedge clk);
            end
            dev_clk_drv = 1'b0;
            repeat (HALF) @(negedge clk);
            dev_clk_drv = 1'b1;
            if (n < FRAME_EDGES) s[n] = ps2_data_line;
            repeat (HALF) @(negedge clk);
        end
        dev_data_drv = 1'b1;
    endtask

    task automatic wait_done_cnt(input int target, input int budget);
        int w = 0;
        while (done_cnt < target && w < budget) begin
            @(negedge clk);
            #1;
            w++;
        end
        if (done_cnt < target) bound_fail("done_wait");
    endtask

    task automatic xfer(input logic [7:0] b, input logic ack, output logic [10:0] s);
        int base = done_cnt;
        exp_ack_err = ~ack;
        exp_to_err  = 1'b0;
        fork
            send(b);
            dev_run(FRAME_EDGES, ack, s);
        join
        wait_done_cnt(base + 1, 200);
        repeat (20) @(negedge clk);
        check("done_once", 32'(done_cnt), 32'(base + 1));
        check("frame_vs_model", 32'(s), 32'(model_frame(b)));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [10:0] s;
        int base;
        int w;

        repeat (3) @(negedge clk);
        check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
        check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd0);
        check("rst_busy", 32'(tx_busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 32'(tx_ready), 32'd1);

        // 0xED with ACK: hand-computed frame start0, ED LSB first, parity 1, stop 1
        xfer(CMD_SET_LED, 1'b1, s);
        check("ed_frame_literal", 32'(s), 32'(11'b1_1_11101101_0));
        check("ed_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

        xfer(8'h00, 1'b1, s);
        check("parity_00", 32'(s[9]), 32'd1);
        check("ready_between", 32'(tx_ready), 32'd1);
        xfer(8'h01, 1'b1, s);
        check("parity_01", 32'(s[9]), 32'd0);

        // No ACK from the device
        xfer(CMD_SET_LED, 1'b0, s);
        check("noack_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);

        // Device never clocks
        base        = done_cnt;
        exp_ack_err = 1'b0;
        exp_to_err  = 1'b1;
        send(CMD_RESET);
        wait_done_cnt(base + 1, INH + TMO + 100);
        check("to_done_level", 32'(done), 32'd1);
        check("to_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        @(negedge clk);
        check("to_ready_next", 32'(tx_ready), 32'd1);
        exp_to_err = 1'b0;

        // Reset after the fifth device clock fall
        base        = done_cnt;
        exp_ack_err = 1'b0;
        fork
            send(CMD_SET_LED);
            dev_run(5, 1'b1, s);
        join
        check("pre_rst_busy", 32'(tx_busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_lines", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(tx_ready), 32'd1);
        check("midrst_no_done", 32'(done_cnt), 32'(base));
        xfer(CMD_ENABLE, 1'b1, s);
        check("parity_f4", 32'(s[9]), 32'd0);

        // tx_valid chatter with 0x55 during SHIFT must be ignored
        base        = done_cnt;
        exp_ack_err = 1'b0;
        fork
            send(CMD_SET_LED);
            dev_run(FRAME_EDGES, 1'b1, s);
            begin
                w = 0;
                while (!(!ps2_clk_oe && ps2_data_oe) && w < 400) begin
                    @(negedge clk);
                    w++;
                end
                for (int i = 0; i < 40; i++) begin
                    tx_data  = 8'h55;
                    tx_valid = ~tx_valid;
                    repeat (7) @(negedge clk);
                end
                tx_valid = 1'b0;
            end
        join
        wait_done_cnt(base + 1, 200);
        repeat (100) @(negedge clk);
        check("chatter_single_done", 32'(done_cnt), 32'(base + 1));
        check("chatter_frame", 32'(s), 32'(11'b1_1_11101101_0));
        check("chatter_idle", 32'(tx_busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
